// File: rtl/mul_hilo_ctrl_if.sv
// Request channel from EX into the HI/LO multiply controller.
// Valid/ready handshake; an op is taken on an edge with valid & ready.
interface mul_hilo_ctrl_if;
    logic        req_valid;
    logic [2:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        req_ready;

    modport master (
        output req_valid,
        output req_op,
        output req_a,
        output req_b,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_op,
        input  req_a,
        input  req_b,
        output req_ready
    );
endinterface

// File: rtl/mul_hilo_ctrl.sv
// Issue/writeback controller between EX and the pipelined 32x32 multiplier.
// Owns architectural HI/LO and stalls dependent ops while a product is pending.
module mul_hilo_ctrl #(
    parameter int MUL_LATENCY = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    mul_hilo_ctrl_if.slave       req,
    input  logic                 flush,
    output logic [31:0]          mul_a,
    output logic [31:0]          mul_b,
    output logic                 mul_signed,
    input  logic [63:0]          mul_result,
    output logic [31:0]          hi,
    output logic [31:0]          lo,
    output logic                 busy,
    output logic                 done
);

    localparam int CW = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(MUL_LATENCY - 1);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_MADD  = 3'd2;
    localparam logic [2:0] OP_MADDU = 3'd3;
    localparam logic [2:0] OP_MSUB  = 3'd4;
    localparam logic [2:0] OP_MSUBU = 3'd5;
    localparam logic [2:0] OP_MTHI  = 3'd6;
    localparam logic [2:0] OP_MTLO  = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_WB   = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] a_d, b_d;
    logic        sg_d;
    logic [31:0] hi_d, lo_d;
    logic        busy_d, done_d;

    logic        accept;
    logic        req_is_mul;
    logic        req_is_signed;
    logic [63:0] acc;
    logic [63:0] wb_val;

    assign req.req_ready = ~busy & ~flush;
    assign accept        = req.req_valid & req.req_ready;

    // Ops 0-5 go through the multiplier; 6/7 are direct HI/LO moves
    assign req_is_mul    = ~(req.req_op[2] & req.req_op[1]);
    assign req_is_signed = req_is_mul & ~req.req_op[0];

    assign acc = {hi, lo};

    always_comb begin
        wb_val = mul_result;
        unique case (1'b1)
            (op_q == OP_MADD) || (op_q == OP_MADDU): wb_val = acc + mul_result;
            (op_q == OP_MSUB) || (op_q == OP_MSUBU): wb_val = acc - mul_result;
            default:                                 wb_val = mul_result;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = mul_a;
        b_d     = mul_b;
        sg_d    = mul_signed;
        hi_d    = hi;
        lo_d    = lo;
        busy_d  = busy;
        done_d  = 1'b0;

        if (flush) begin
            // Cancels any pending write; operand regs left stale on purpose
            state_d = S_IDLE;
            busy_d  = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        if (req_is_mul) begin
                            a_d     = req.req_a;
                            b_d     = req.req_b;
                            sg_d    = req_is_signed;
                            op_d    = req.req_op;
                            cnt_d   = CNT_INIT;
                            busy_d  = 1'b1;
                            state_d = S_WAIT;
                        end else if (req.req_op == OP_MTHI) begin
                            hi_d = req.req_a;
                        end else begin
                            lo_d = req.req_a;
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt_q == '0) begin
                        state_d = S_WB;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                S_WB: begin
                    {hi_d, lo_d} = wb_val;
                    busy_d       = 1'b0;
                    done_d       = 1'b1;
                    state_d      = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            op_q       <= '0;
            mul_a      <= '0;
            mul_b      <= '0;
            mul_signed <= 1'b0;
            hi         <= '0;
            lo         <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            mul_a      <= a_d;
            mul_b      <= b_d;
            mul_signed <= sg_d;
            hi         <= hi_d;
            lo         <= lo_d;
            busy       <= busy_d;
            done       <= done_d;
        end
    end

endmodule

// File: tb/tb_mul_hilo_ctrl.sv
// Self-checking bench for mul_hilo_ctrl with a 2-stage multiplier model.
// Expected HI/LO come from a 64-bit arithmetic model of the op semantics.
module tb_mul_hilo_ctrl;

    localparam int L = 2;

    logic        clk;
    logic        reset;
    logic        flush;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic        mul_signed;
    logic [63:0] mul_result;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;

    logic [63:0] stage1;

    int tests;
    int fails;

    logic [63:0] m_hilo;

    mul_hilo_ctrl_if bus ();

    mul_hilo_ctrl #(.MUL_LATENCY(L)) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (bus),
        .flush      (flush),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_signed (mul_signed),
        .mul_result (mul_result),
        .hi         (hi),
        .lo         (lo),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Two register stages, like the real multiplier
    always_ff @(posedge clk) begin
        if (mul_signed)
            stage1 <= {{32{mul_a[31]}}, mul_a} * {{32{mul_b[31]}}, mul_b};
        else
            stage1 <= {32'b0, mul_a} * {32'b0, mul_b};
        mul_result <= stage1;
    end

    function automatic logic [63:0] ref_prod(logic [2:0] op,
                                             logic [31:0] a,
                                             logic [31:0] b);
        longint sa;
        longint sb;
        longint unsigned ua;
        longint unsigned ub;
        sa = longint'(int'(a));
        sb = longint'(int'(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        if (op[0] == 1'b0) return 64'(sa * sb);
        return ua * ub;
    endfunction

    function automatic logic [63:0] ref_op(logic [2:0] op,
                                           logic [31:0] a,
                                           logic [31:0] b,
                                           logic [63:0] cur);
        case (op)
            3'd0, 3'd1: return ref_prod(op, a, b);
            3'd2, 3'd3: return cur + ref_prod(op, a, b);
            3'd4, 3'd5: return cur - ref_prod(op, a, b);
            3'd6:       return {a, cur[31:0]};
            default:    return {cur[63:32], a};
        endcase
    endfunction

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one op and follow it to completion, checking timing and result
    task automatic run_op(logic [2:0] op, logic [31:0] a, logic [31:0] b);
        logic [63:0] old;
        old = m_hilo;
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_a     = a;
        bus.req_b     = b;
        #1;
        check("ready_before_issue", 64'(bus.req_ready), 64'd1);
        step();
        bus.req_valid = 1'b0;
        m_hilo = ref_op(op, a, b, old);
        if (op < 3'd6) begin
            for (int i = 0; i <= L; i++) begin
                check("busy_in_flight", 64'(busy), 64'd1);
                check("done_in_flight", 64'(done), 64'd0);
                check("hilo_held", {hi, lo}, old);
                step();
            end
            check("busy_after_wb", 64'(busy), 64'd0);
            check("done_pulse", 64'(done), 64'd1);
            check("hilo_result", {hi, lo}, m_hilo);
            step();
            check("done_cleared", 64'(done), 64'd0);
        end else begin
            check("mt_busy", 64'(busy), 64'd0);
            check("mt_done", 64'(done), 64'd0);
            check("mt_hilo", {hi, lo}, m_hilo);
        end
    endtask

    initial begin
        logic [63:0] saved;
        logic [2:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;

        tests         = 0;
        fails         = 0;
        m_hilo        = '0;
        reset         = 1'b1;
        flush         = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_op    = 3'd0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("rst_hilo", {hi, lo}, 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_mul_a", 64'(mul_a), 64'd0);
        check("rst_ready", 64'(bus.req_ready), 64'd1);
        step();

        // Directed arithmetic cases
        run_op(3'd0, 32'hFFFF_FFFD, 32'h0000_0007);
        check("mult_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("multu_max", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
        run_op(3'd6, 32'h0000_0001, 32'h0);
        run_op(3'd7, 32'hFFFF_FFFF, 32'h0);
        run_op(3'd3, 32'h1, 32'h1);
        check("maddu_carry", {hi, lo}, 64'h0000_0002_0000_0000);
        run_op(3'd4, 32'h2, 32'h1);
        check("msub_borrow", {hi, lo}, 64'h0000_0001_FFFF_FFFE);

        // Valid held high: second accept one edge after the WB edge
        bus.req_valid = 1'b1;
        bus.req_op    = 3'd0;
        bus.req_a     = 32'd5;
        bus.req_b     = 32'd6;
        #1;
        step();
        for (int i = 0; i <= L; i++) begin
            check("bb_ready_low", 64'(bus.req_ready), 64'd0);
            check("bb_busy", 64'(busy), 64'd1);
            if (i == L) bus.req_a = 32'd7;
            step();
        end
        check("bb_first_done", 64'(done), 64'd1);
        check("bb_first_res", {hi, lo}, 64'd30);
        check("bb_idle_gap", 64'(busy), 64'd0);
        step();
        bus.req_valid = 1'b0;
        check("bb_second_acc", 64'(busy), 64'd1);
        check("bb_second_a", 64'(mul_a), 64'd7);
        for (int i = 0; i <= L; i++) step();
        check("bb_second_res", {hi, lo}, 64'd42);
        m_hilo = 64'd42;
        step();

        // Flush during WB suppresses the write
        saved = {hi, lo};
        bus.req_valid = 1'b1;
        bus.req_op    = 3'd0;
        bus.req_a     = 32'd9;
        bus.req_b     = 32'd9;
        step();
        bus.req_valid = 1'b0;
        repeat (L) step();
        flush = 1'b1;
        #1;
        check("flush_ready_low", 64'(bus.req_ready), 64'd0);
        step();
        flush = 1'b0;
        check("flush_hilo", {hi, lo}, saved);
        check("flush_busy", 64'(busy), 64'd0);
        check("flush_done", 64'(done), 64'd0);
        #1;
        check("flush_ready_back", 64'(bus.req_ready), 64'd1);
        step();
        check("flush_no_late_done", 64'(done), 64'd0);
        check("flush_hilo_late", {hi, lo}, saved);

        // Flush and valid together in IDLE: nothing accepted
        bus.req_valid = 1'b1;
        bus.req_op    = 3'd6;
        bus.req_a     = 32'hDEAD_BEEF;
        flush         = 1'b1;
        step();
        check("flush_idle_mthi", {hi, lo}, saved);
        bus.req_op = 3'd0;
        step();
        check("flush_idle_mult", 64'(busy), 64'd0);
        bus.req_valid = 1'b0;
        flush         = 1'b0;
        step();

        // Async reset in the middle of WAIT
        bus.req_valid = 1'b1;
        bus.req_op    = 3'd0;
        bus.req_a     = 32'd4;
        bus.req_b     = 32'd5;
        step();
        bus.req_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check("arst_hilo", {hi, lo}, 64'd0);
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_done", 64'(done), 64'd0);
        #1;
        reset = 1'b0;
        m_hilo = '0;
        step();
        run_op(3'd0, 32'd2, 32'd3);
        check("post_rst_mult", {hi, lo}, 64'd6);

        // Random ops against the model
        for (int n = 0; n < 40; n++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = $urandom;
            if (n % 5 == 0) ra = 32'hFFFF_FFFF;
            if (n % 7 == 0) rb = 32'h8000_0000;
            run_op(rop, ra, rb);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout tests=%0d", tests);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mul_hilo_ctrl.md
Name: mul_hilo_ctrl

Overview:
Issue and writeback controller that sits between the EX stage and the 2-stage pipelined 32x32 multiplier. It accepts MULT-class requests and latches operands that drive the multiplier. It waits out the multiplier latency, then writes, accumulates into, or subtracts from the architectural HI/LO pair. It raises busy so the pipeline stalls MFHI/MFLO and subsequent multiply ops until HI/LO are final.

Parameters:
MUL_LATENCY, 2, clock edges from operands stable at the multiplier inputs to a valid mul_result (matches the multiplier's two register stages)

Ports:
clk  in  1  single clock; all state updates on its rising edge
reset  in  1  asynchronous, active-high; one clock; reset is asynchronous and active-high
req_valid  in  1  EX presents an op this cycle
req_op  in  3  0 MULT, 1 MULTU, 2 MADD, 3 MADDU, 4 MSUB, 5 MSUBU, 6 MTHI, 7 MTLO
req_a  in  32  rs operand
req_b  in  32  rt operand (ignored for MTHI/MTLO)
req_ready  out  1  = ~busy & ~flush; request accepted on an edge where req_valid & req_ready
flush  in  1  cancels any in-flight multiply (exception/eret); HI/LO untouched
mul_a  out  32  registered operand A to multiplier
mul_b  out  32  registered operand B to multiplier
mul_signed  out  1  registered signed_en to multiplier
mul_result  in  64  product from multiplier
hi  out  32  architectural HI
lo  out  32  architectural LO
busy  out  1  multiply in flight; stall MFHI/MFLO and further req
done  out  1  one-cycle pulse, the cycle after HI/LO were updated by a multiply-class op

Behaviour:
- Reset (async): state IDLE; hi, lo, mul_a, mul_b, mul_signed, busy, done, counter, op register all 0.
- States: IDLE, WAIT, WB.
- IDLE: on accept of ops 0-5: mul_a<=req_a, mul_b<=req_b, mul_signed<=(op is MULT/MADD/MSUB), latch op, cnt<=MUL_LATENCY-1, busy<=1, go WAIT.
- IDLE: on accept of MTHI: hi<=req_a. On accept of MTLO: lo<=req_a. Both stay IDLE, busy stays 0, no done.
- WAIT: operands held stable; cnt decrements each edge; when cnt==0, go WB.
- WB: mul_result is valid this cycle. On the edge: {hi,lo}<= P for MULT/MULTU, {hi,lo}+P for MADD/MADDU, {hi,lo}-P for MSUB/MSUBU.
  - P is mul_result; 64-bit modulo 2^64 arithmetic, no overflow flag.
  - Same edge: busy<=0, done<=1, go IDLE.
- Timing: accept at edge E0 -> HI/LO written at edge E0+MUL_LATENCY+1 -> done high for the cycle after that edge.
- busy high from after E0 through the WB edge. req_ready=0 throughout, so there are no back-to-back issues. The earliest next accept is the edge after the WB edge.
- done: deasserted on every edge where it was not just set.
- flush, any state: next edge -> IDLE, busy<=0, done<=0, HI/LO unchanged.
  - flush during WB suppresses the write.
  - flush with req_valid in IDLE: flush wins, nothing accepted; req_ready is low whenever flush is high.
- mul_a/mul_b/mul_signed are not cleared by flush; stale values are harmless.
- Reset asserted mid-operation: immediate return to reset values, including HI/LO=0.
- MUL_LATENCY must be >=1. For MUL_LATENCY=1, WAIT lasts exactly one cycle.

Test Plan:
- MULT -3 x 7 (0xFFFFFFFD, 0x00000007), accepted at edge 0: busy 1 for edges 1-3. Edge 3 gives hi=0xFFFFFFFF, lo=0xFFFFFFEB; done pulses in the following cycle.
- MULTU 0xFFFFFFFF x 0xFFFFFFFF: hi=0xFFFFFFFE, lo=0x00000001.
- MTHI 0x00000001, MTLO 0xFFFFFFFF, then MADDU 1x1: {hi,lo}=0x00000002_00000000. Then MSUB 2x1: {hi,lo}=0x00000001_FFFFFFFE.
- req_valid held high continuously with MULT ops: second accept occurs exactly one edge after the first WB edge. req_ready is never high while busy.
- MULT issued then flush in WB cycle: HI/LO keep prior values, done stays 0, req_ready returns high next cycle. Repeat with flush and req_valid in the same IDLE cycle: no accept.
- Async reset pulse mid-WAIT (between clock edges): hi, lo, busy, done read 0 before the next clk edge. A following MULT 2x3 completes normally with lo=6, hi=0.
